// File: rtl/issue_scoreboard_if.sv
// Issue-stage bundle between the decoder/execute side and the scoreboard
// controller. The master side drives decode, writeback and branch-resolution
// information. The slave side (the controller) returns the issue handshake,
// the flush pulse and status.
interface issue_scoreboard_if #(
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // decode side
    logic          id_valid;
    logic          id_ready;
    logic          rs1_use;
    logic          rs2_use;
    logic          rd_use;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [4:0]    rd_addr;
    logic          mem_op;
    logic          mdu_op;
    logic          is_branch;

    // long-latency writeback
    logic          wb_valid;
    logic [4:0]    wb_addr;

    // branch resolution
    logic          br_resolved;
    logic          br_taken;

    // controller outputs
    logic          id_flush;
    logic          busy;
    logic [31:0]   sb_pending;
    logic [CW-1:0] outstanding_cnt;

    modport master (
        output id_valid, rs1_use, rs2_use, rd_use, rs1_addr, rs2_addr, rd_addr,
        output mem_op, mdu_op, is_branch, wb_valid, wb_addr, br_resolved, br_taken,
        input  id_ready, id_flush, busy, sb_pending, outstanding_cnt
    );

    modport slave (
        input  id_valid, rs1_use, rs2_use, rd_use, rs1_addr, rs2_addr, rd_addr,
        input  mem_op, mdu_op, is_branch, wb_valid, wb_addr, br_resolved, br_taken,
        output id_ready, id_flush, busy, sb_pending, outstanding_cnt
    );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Decode-stage issue controller.
// Tracks destination registers of in-flight long-latency ops (loads and MDU)
// in a 32-entry pending scoreboard. Issue is stalled when any of these holds:
//   - a source or destination hits a pending entry (RAW/WAW),
//   - the outstanding-op budget is full for a long-latency op,
//   - one branch is still unresolved.
// A taken branch resolution produces a one-cycle registered flush pulse.
module issue_scoreboard_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    issue_scoreboard_if.slave  bus
);
    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_ISSUE   = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    state_t        state_reg;
    logic          flush_reg;
    logic [31:0]   sb_reg;
    logic [31:0]   sb_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    logic          longlat;
    logic          hazard;
    logic          budget_full;
    logic          ready;
    logic          issue;
    logic          sb_set;
    logic          cnt_inc;
    logic          cnt_dec;

    // Only ops that actually write a real register occupy a scoreboard slot.
    // A write to x0 is not tracked, and neither is an op without a destination.
    assign longlat = (bus.mem_op | bus.mdu_op) & bus.rd_use & (bus.rd_addr != 5'd0);

    // Hazards are judged against the registered scoreboard only. A writeback
    // in the same cycle releases the stall one cycle later, not immediately.
    assign hazard = (bus.rs1_use & sb_reg[bus.rs1_addr])
                  | (bus.rs2_use & sb_reg[bus.rs2_addr])
                  | (bus.rd_use  & sb_reg[bus.rd_addr]);

    assign budget_full = longlat & (cnt_reg == CNT_MAX);

    // Ready does not look at id_valid, so there is no valid->ready
    // combinational path. Ready is also held low during reset.
    assign ready = ~rst & (state_reg == ST_ISSUE) & ~hazard & ~budget_full;
    assign issue = bus.id_valid & ready;

    assign sb_set  = issue & longlat;
    assign cnt_inc = sb_set;
    // A writeback always retires one op, even if its bit was already clear.
    // The count saturates at zero so a stale writeback after reset is harmless.
    assign cnt_dec = bus.wb_valid & (cnt_reg != '0);

    // Per-register next-state. When the set and the clear hit the same
    // register, the set wins. Entry 0 (x0) is never pending.
    assign sb_next[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
        logic set_hit;
        logic clr_hit;
        assign set_hit     = sb_set & (bus.rd_addr == 5'(gi));
        assign clr_hit     = bus.wb_valid & (bus.wb_addr == 5'(gi));
        assign sb_next[gi] = set_hit | (sb_reg[gi] & ~clr_hit);
    end

    // Outstanding count: an issue and a retire in the same cycle cancel out.
    always_comb begin
        cnt_next = cnt_reg;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // Scoreboard and outstanding-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            sb_reg  <= sb_next;
            cnt_reg <= cnt_next;
        end
    end

    // Branch FSM with registered flush. While in BR_WAIT, writebacks keep
    // updating the scoreboard. A resolution seen in ISSUE is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ISSUE;
            flush_reg <= 1'b0;
        end else begin
            flush_reg <= 1'b0;
            case (state_reg)
                ST_ISSUE: begin
                    if (issue && bus.is_branch) begin
                        state_reg <= ST_BR_WAIT;
                    end
                end
                ST_BR_WAIT: begin
                    if (bus.br_resolved) begin
                        state_reg <= ST_ISSUE;
                        flush_reg <= bus.br_taken;
                    end
                end
                default: state_reg <= ST_ISSUE;
            endcase
        end
    end

    assign bus.id_ready        = ready;
    assign bus.id_flush        = flush_reg;
    assign bus.sb_pending      = sb_reg;
    assign bus.outstanding_cnt = cnt_reg;
    assign bus.busy            = (state_reg != ST_ISSUE) | (cnt_reg != '0);

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Testbench for issue_scoreboard_ctrl.
// The expected behaviour comes from a reference model that holds:
//   - a pending-register set,
//   - an in-flight count,
//   - a branch-wait flag.
// The stimulus consists of directed scenarios followed by randomized cycles.
module tb_issue_scoreboard_ctrl;
    localparam int MAX_OUT = 4;
    localparam int CW      = $clog2(MAX_OUT + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_scoreboard_if #(.MAX_OUTSTANDING(MAX_OUT)) bus();

    issue_scoreboard_ctrl #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    // reference model state
    logic [31:0] m_sb;
    int          m_cnt;
    bit          m_wait;
    bit          m_flush;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.id_valid    = 1'b0;
        bus.rs1_use     = 1'b0;
        bus.rs2_use     = 1'b0;
        bus.rd_use      = 1'b0;
        bus.rs1_addr    = 5'd0;
        bus.rs2_addr    = 5'd0;
        bus.rd_addr     = 5'd0;
        bus.mem_op      = 1'b0;
        bus.mdu_op      = 1'b0;
        bus.is_branch   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
    endtask

    // op: kind 0=alu 1=load 2=mdu 3=branch
    task automatic drive_op(input int kind, input logic rdu, input logic [4:0] rd,
                            input logic r1u, input logic [4:0] rs1,
                            input logic r2u, input logic [4:0] rs2);
        bus.id_valid  = 1'b1;
        bus.mem_op    = (kind == 1);
        bus.mdu_op    = (kind == 2);
        bus.is_branch = (kind == 3);
        bus.rd_use    = rdu;
        bus.rd_addr   = rd;
        bus.rs1_use   = r1u;
        bus.rs1_addr  = rs1;
        bus.rs2_use   = r2u;
        bus.rs2_addr  = rs2;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a);
        bus.wb_valid = v;
        bus.wb_addr  = a;
    endtask

    task automatic model_reset();
        m_sb    = '0;
        m_cnt   = 0;
        m_wait  = 1'b0;
        m_flush = 1'b0;
    endtask

    // One clock: compare the DUT against the model just before the edge,
    // then advance the model over the edge. Inputs must already be driven
    // (at the falling edge).
    task automatic step(input string tag);
        bit ll, haz, exp_ready, iss, dec;
        #1;
        ll  = (bus.mem_op || bus.mdu_op) && bus.rd_use && (bus.rd_addr != 5'd0);
        haz = (bus.rs1_use && m_sb[bus.rs1_addr]) || (bus.rs2_use && m_sb[bus.rs2_addr])
           || (bus.rd_use && m_sb[bus.rd_addr]);
        exp_ready = !rst && !m_wait && !haz && !(ll && m_cnt == MAX_OUT);
        iss = bus.id_valid && exp_ready;
        check_val({tag, ".ready"}, 32'(bus.id_ready), 32'(exp_ready));
        check_val({tag, ".sb"},    bus.sb_pending, m_sb);
        check_val({tag, ".cnt"},   32'(bus.outstanding_cnt), 32'(m_cnt));
        check_val({tag, ".flush"}, 32'(bus.id_flush), 32'(m_flush));
        check_val({tag, ".busy"},  32'(bus.busy), 32'(m_wait || m_cnt != 0));
        if (iss)
            $display("issue %-10s rd=x%0d ll=%0b br=%0b wb=%0b/x%0d cnt=%0d",
                     tag, bus.rd_addr, ll, bus.is_branch, bus.wb_valid, bus.wb_addr, m_cnt);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_flush = m_wait && bus.br_resolved && bus.br_taken;
            if (m_wait && bus.br_resolved) m_wait = 1'b0;
            else if (iss && bus.is_branch) m_wait = 1'b1;
            dec = bus.wb_valid && (m_cnt > 0);
            if (bus.wb_valid) m_sb[bus.wb_addr] = 1'b0;
            if (iss && ll) m_sb[bus.rd_addr] = 1'b1;
            m_sb[0] = 1'b0;
            m_cnt = m_cnt + ((iss && ll) ? 1 : 0) - (dec ? 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step("rst");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // reset state
        step("reset");
        rst = 1'b0;
        check_val("reset.sb", bus.sb_pending, 32'h0);
        check_val("reset.cnt", 32'(bus.outstanding_cnt), 32'd0);
        check_val("reset.flush", 32'(bus.id_flush), 32'd0);

        // lw x5 then dependent add x6,x5,x1
        drive_op(1, 1, 5'd5, 1, 5'd2, 0, 5'd0);
        step("lw5");
        idle_inputs();
        check_val("lw5.sb", bus.sb_pending, 32'h20);
        check_val("lw5.cnt", 32'(bus.outstanding_cnt), 32'd1);
        drive_op(0, 1, 5'd6, 1, 5'd5, 1, 5'd1);
        #1 check_val("raw.stall", 32'(bus.id_ready), 32'd0);
        step("raw_a");
        step("raw_b");
        drive_wb(1, 5'd5);
        #1 check_val("raw.nobypass", 32'(bus.id_ready), 32'd0);
        step("raw_wb");
        drive_wb(0, 5'd0);
        #1 check_val("raw.release", 32'(bus.id_ready), 32'd1);
        step("add6");
        idle_inputs();

        // budget: four loads fill it, an ALU op still goes, a writeback frees a slot
        for (int i = 1; i <= 4; i++) begin
            drive_op(1, 1, 5'(i), 0, 5'd0, 0, 5'd0);
            step("lw_fill");
        end
        drive_op(1, 1, 5'd7, 0, 5'd0, 0, 5'd0);
        #1 check_val("full.stall", 32'(bus.id_ready), 32'd0);
        check_val("full.cnt", 32'(bus.outstanding_cnt), 32'd4);
        step("lw7_stall");
        drive_op(0, 1, 5'd8, 1, 5'd9, 1, 5'd10);
        #1 check_val("full.alu", 32'(bus.id_ready), 32'd1);
        step("add8");
        drive_op(1, 1, 5'd7, 0, 5'd0, 0, 5'd0);
        drive_wb(1, 5'd2);
        step("lw7_wb2");
        drive_wb(0, 5'd0);
        #1 check_val("full.freed", 32'(bus.id_ready), 32'd1);
        step("lw7");
        idle_inputs();
        check_val("full.sb", bus.sb_pending, 32'h9A);
        foreach (m_sb[i]) begin
            if (m_sb[i]) begin
                drive_wb(1, 5'(i));
                step("drain");
            end
        end
        idle_inputs();

        // branch taken: stall until resolved, then one-cycle flush
        drive_op(3, 0, 5'd0, 1, 5'd1, 1, 5'd2);
        step("beq_t");
        drive_op(0, 1, 5'd3, 0, 5'd0, 0, 5'd0);
        #1 check_val("br.stall", 32'(bus.id_ready), 32'd0);
        step("br_wait");
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b1;
        step("br_res_t");
        idle_inputs();
        check_val("br.flush1", 32'(bus.id_flush), 32'd1);
        check_val("br.busy", 32'(bus.busy), 32'd0);
        step("br_after");
        check_val("br.flush0", 32'(bus.id_flush), 32'd0);
        // not-taken branch
        drive_op(3, 0, 5'd0, 1, 5'd1, 0, 5'd0);
        step("beq_nt");
        idle_inputs();
        bus.br_resolved = 1'b1;
        step("br_res_nt");
        idle_inputs();
        check_val("br.noflush", 32'(bus.id_flush), 32'd0);
        // a resolution seen in ISSUE is ignored
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b1;
        step("br_stray");
        idle_inputs();
        check_val("br.stray", 32'(bus.id_flush), 32'd0);

        // same-cycle issue and writeback
        drive_op(1, 1, 5'd1, 0, 5'd0, 0, 5'd0);
        step("lw1");
        drive_op(1, 1, 5'd2, 0, 5'd0, 0, 5'd0);
        step("lw2");
        drive_op(1, 1, 5'd3, 0, 5'd0, 0, 5'd0);
        drive_wb(1, 5'd1);
        step("lw3_wb1");
        idle_inputs();
        check_val("same.cnt", 32'(bus.outstanding_cnt), 32'd2);
        check_val("same.sb", bus.sb_pending, 32'h0C);

        // x0 destination and MDU without destination are not tracked
        drive_op(1, 1, 5'd0, 0, 5'd0, 0, 5'd0);
        #1 check_val("x0.ready", 32'(bus.id_ready), 32'd1);
        step("lw0");
        drive_op(2, 0, 5'd9, 1, 5'd4, 0, 5'd0);
        step("mdu_nord");
        idle_inputs();
        check_val("x0.sb", bus.sb_pending, 32'h0C);
        check_val("x0.cnt", 32'(bus.outstanding_cnt), 32'd2);

        // reset while waiting on a branch with three ops in flight
        drive_op(2, 1, 5'd4, 0, 5'd0, 0, 5'd0);
        step("mdu4");
        drive_op(3, 0, 5'd0, 1, 5'd5, 0, 5'd0);
        step("beq_r");
        idle_inputs();
        check_val("pre.cnt", 32'(bus.outstanding_cnt), 32'd3);
        do_reset();
        check_val("mid.sb", bus.sb_pending, 32'h0);
        check_val("mid.cnt", 32'(bus.outstanding_cnt), 32'd0);
        check_val("mid.busy", 32'(bus.busy), 32'd0);
        drive_wb(1, 5'd4);
        step("stale_wb");
        idle_inputs();
        check_val("stale.cnt", 32'(bus.outstanding_cnt), 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int kind;
            idle_inputs();
            rst  = ($urandom_range(0, 199) == 0);
            kind = $urandom_range(0, 9);
            bus.id_valid  = ($urandom_range(0, 3) != 0);
            bus.mem_op    = (kind <= 3);
            bus.mdu_op    = (kind == 4 || kind == 5);
            bus.is_branch = (kind == 6);
            bus.rd_use    = (kind != 6) && ($urandom_range(0, 7) != 0);
            bus.rd_addr   = 5'($urandom_range(0, 7));
            bus.rs1_use   = $urandom_range(0, 1);
            bus.rs1_addr  = 5'($urandom_range(0, 7));
            bus.rs2_use   = $urandom_range(0, 1);
            bus.rs2_addr  = 5'($urandom_range(0, 7));
            bus.wb_valid  = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = 5'($urandom_range(0, 7));
            bus.br_resolved = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.br_taken  = $urandom_range(0, 1);
            step("rand");
        end
        rst = 1'b0;
        idle_inputs();
        step("final");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
